// File: rtl/cascade_mod_counter.sv
// Up/down modulo counter with a non-zero floor, optional runtime ceiling, clamped
// preset load, wrap/saturate mode and registered one-cycle carry/borrow pulses.
module cascade_mod_counter #(
    parameter int W       = 6,
    parameter int MIN     = 0,
    parameter int MAX     = 59,
    parameter int DYN_LIM = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_down,
    input  logic         sat,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic [W-1:0] lim,
    output logic [W-1:0] count,
    output logic         tc_up,
    output logic         tc_dn,
    output logic         at_max,
    output logic         at_min
);

    // One extra bit keeps compares and +1 safe when the ceiling is 2^W-1.
    localparam logic [W:0] MIN_X = (W+1)'(MIN);
    localparam logic [W:0] MAX_X = (W+1)'(MAX);

    logic [W:0]   hi;
    logic [W:0]   cnt_x;
    logic [W:0]   ld_x;
    logic [W:0]   lim_x;
    logic [W-1:0] count_nxt;
    logic         tc_up_nxt;
    logic         tc_dn_nxt;

    assign cnt_x = {1'b0, count};
    assign ld_x  = {1'b0, ld_val};
    assign lim_x = {1'b0, lim};

    always_comb begin
        hi = MAX_X;
        if (DYN_LIM != 0) begin
            if (lim_x < MIN_X)
                hi = MIN_X;
            else if (lim_x > MAX_X)
                hi = MAX_X;
            else
                hi = lim_x;
        end
    end

    // Priority: load, then pull an out-of-range count down to hi, then step.
    always_comb begin
        count_nxt = count;
        tc_up_nxt = 1'b0;
        tc_dn_nxt = 1'b0;
        if (ld) begin
            if (ld_x < MIN_X)
                count_nxt = MIN_X[W-1:0];
            else if (ld_x > hi)
                count_nxt = hi[W-1:0];
            else
                count_nxt = ld_val;
        end else if (cnt_x > hi) begin
            count_nxt = hi[W-1:0];
        end else if (en) begin
            if (!up_down) begin
                if (cnt_x < hi) begin
                    count_nxt = cnt_x[W-1:0] + 1'b1;
                end else if (!sat) begin
                    count_nxt = MIN_X[W-1:0];
                    tc_up_nxt = 1'b1;
                end
            end else begin
                if (cnt_x > MIN_X) begin
                    count_nxt = cnt_x[W-1:0] - 1'b1;
                end else if (!sat) begin
                    count_nxt = hi[W-1:0];
                    tc_dn_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= MIN_X[W-1:0];
            tc_up <= 1'b0;
            tc_dn <= 1'b0;
        end else begin
            count <= count_nxt;
            tc_up <= tc_up_nxt;
            tc_dn <= tc_dn_nxt;
        end
    end

    assign at_max = (cnt_x == hi);
    assign at_min = (cnt_x == MIN_X);

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Directed bench for cascade_mod_counter: three instances cover seconds (0..59),
// hours (1..12) and a runtime-limited day-of-month field (1..31).
module tb_cascade_mod_counter;

    logic clk;
    logic rst;

    logic       a_en, a_ud, a_sat, a_ld;
    logic [5:0] a_val, a_lim, a_count;
    logic       a_up, a_dn, a_max, a_min;

    logic       b_en, b_ud, b_sat, b_ld;
    logic [3:0] b_val, b_lim, b_count;
    logic       b_up, b_dn, b_max, b_min;

    logic       c_en, c_ud, c_sat, c_ld;
    logic [4:0] c_val, c_lim, c_count;
    logic       c_up, c_dn, c_max, c_min;

    // Expected word: {at_max, at_min, tc_up, tc_dn, count[5:0]}
    logic [9:0] exp_q[$];
    int n_cmp;
    int n_bad;

    cascade_mod_counter #(.W(6), .MIN(0), .MAX(59), .DYN_LIM(0)) u_a (
        .clk(clk), .rst(rst), .en(a_en), .up_down(a_ud), .sat(a_sat), .ld(a_ld),
        .ld_val(a_val), .lim(a_lim), .count(a_count), .tc_up(a_up), .tc_dn(a_dn),
        .at_max(a_max), .at_min(a_min)
    );

    cascade_mod_counter #(.W(4), .MIN(1), .MAX(12), .DYN_LIM(0)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .up_down(b_ud), .sat(b_sat), .ld(b_ld),
        .ld_val(b_val), .lim(b_lim), .count(b_count), .tc_up(b_up), .tc_dn(b_dn),
        .at_max(b_max), .at_min(b_min)
    );

    cascade_mod_counter #(.W(5), .MIN(1), .MAX(31), .DYN_LIM(1)) u_c (
        .clk(clk), .rst(rst), .en(c_en), .up_down(c_ud), .sat(c_sat), .ld(c_ld),
        .ld_val(c_val), .lim(c_lim), .count(c_count), .tc_up(c_up), .tc_dn(c_dn),
        .at_max(c_max), .at_min(c_min)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] mk(input int cnt, input logic up, input logic dn,
                                      input logic amax, input logic amin);
        logic [5:0] c6;
        c6 = 6'(cnt);
        return {amax, amin, up, dn, c6};
    endfunction

    function automatic logic [9:0] obs(input int inst);
        logic [9:0] o;
        case (inst)
            0:       o = {a_max, a_min, a_up, a_dn, a_count};
            1:       o = {b_max, b_min, b_up, b_dn, 2'b00, b_count};
            default: o = {c_max, c_min, c_up, c_dn, 1'b0, c_count};
        endcase
        return o;
    endfunction

    // Drivers
    task automatic drive_a(input logic en, input logic ud, input logic s,
                           input logic ld, input int val);
        a_en = en; a_ud = ud; a_sat = s; a_ld = ld; a_val = 6'(val);
    endtask

    task automatic drive_b(input logic en, input logic ud, input logic ld, input int val);
        b_en = en; b_ud = ud; b_ld = ld; b_val = 4'(val);
    endtask

    task automatic drive_c(input logic en, input logic ud, input logic ld,
                           input int val, input int lim);
        c_en = en; c_ud = ud; c_ld = ld; c_val = 5'(val); c_lim = 5'(lim);
    endtask

    // Scoreboard: push expectation, clock once, pop and compare after the edge.
    task automatic tick(input string tag, input int inst, input logic [9:0] e);
        logic [9:0] got;
        logic [9:0] want;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = obs(inst);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, got);
        end else begin
            want = exp_q.pop_front();
            assert (got === want) else begin
                n_bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, got, want);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        drive_a(0, 0, 0, 0, 0); a_lim = '0;
        drive_b(0, 0, 0, 0); b_sat = 1'b0; b_lim = '0;
        drive_c(0, 0, 0, 0, 31); c_sat = 1'b0;
        @(negedge clk);

        tick("rst_a", 0, mk(0, 0, 0, 0, 1));
        tick("rst_b", 1, mk(1, 0, 0, 0, 1));
        tick("rst_c", 2, mk(1, 0, 0, 0, 1));
        rst = 1'b1;

        // Seconds: wrap up through 59
        drive_a(0, 0, 0, 1, 58); tick("a_ld58", 0, mk(58, 0, 0, 0, 0));
        drive_a(1, 0, 0, 0, 0);  tick("a_up59", 0, mk(59, 0, 0, 1, 0));
        tick("a_wrap0", 0, mk(0, 1, 0, 0, 1));
        tick("a_up1", 0, mk(1, 0, 0, 0, 0));
        drive_a(1, 1, 0, 1, 30); tick("a_ld30", 0, mk(30, 0, 0, 0, 0));
        drive_a(1, 1, 0, 0, 0);  tick("a_dn29", 0, mk(29, 0, 0, 0, 0));
        drive_a(0, 1, 0, 0, 0);  tick("a_hold", 0, mk(29, 0, 0, 0, 0));

        // Seconds: saturate at both ends
        drive_a(0, 0, 1, 1, 59); tick("a_ld59s", 0, mk(59, 0, 0, 1, 0));
        drive_a(1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick("a_sat_hi", 0, mk(59, 0, 0, 1, 0));
        drive_a(0, 1, 1, 1, 0);  tick("a_ld0s", 0, mk(0, 0, 0, 0, 1));
        drive_a(1, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) tick("a_sat_lo", 0, mk(0, 0, 0, 0, 1));
        drive_a(0, 0, 0, 0, 0);

        // Hours: borrow from MIN, load clamping and load-over-enable priority
        drive_b(1, 1, 0, 0);  tick("b_wrap12", 1, mk(12, 0, 1, 1, 0));
        drive_b(0, 1, 0, 0);  tick("b_pulse1", 1, mk(12, 0, 0, 1, 0));
        drive_b(0, 0, 1, 0);  tick("b_ld_lo", 1, mk(1, 0, 0, 0, 1));
        drive_b(0, 0, 1, 15); tick("b_ld_hi", 1, mk(12, 0, 0, 1, 0));
        drive_b(1, 0, 1, 5);  tick("b_ld_en", 1, mk(5, 0, 0, 0, 0));
        drive_b(1, 0, 0, 0);  tick("b_up6", 1, mk(6, 0, 0, 0, 0));
        drive_b(0, 0, 0, 0);

        // Day-of-month with runtime limit
        drive_c(0, 0, 1, 31, 31); tick("c_ld31", 2, mk(31, 0, 0, 1, 0));
        drive_c(1, 0, 0, 0, 31);  tick("c_wrap_top", 2, mk(1, 1, 0, 0, 1));
        drive_c(0, 0, 1, 31, 31); tick("c_ld31b", 2, mk(31, 0, 0, 1, 0));
        drive_c(0, 0, 0, 0, 28);  tick("c_clamp28", 2, mk(28, 0, 0, 1, 0));
        drive_c(1, 0, 0, 0, 28);  tick("c_wrap28", 2, mk(1, 1, 0, 0, 1));
        drive_c(1, 0, 0, 0, 0);   tick("c_degen_up", 2, mk(1, 1, 0, 1, 1));
        drive_c(1, 1, 0, 0, 0);   tick("c_degen_dn", 2, mk(1, 0, 1, 1, 1));
        drive_c(0, 0, 0, 0, 31);

        // Reset beats load and a pending wrap
        drive_a(0, 0, 0, 1, 59); tick("a_ld59", 0, mk(59, 0, 0, 1, 0));
        rst = 1'b0;
        drive_a(1, 0, 0, 1, 30); tick("a_rst_dom", 0, mk(0, 0, 0, 0, 1));
        rst = 1'b1;
        drive_a(0, 0, 0, 0, 0);  tick("a_post_rst", 0, mk(0, 0, 0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cascade_mod_counter.md
# cascade_mod_counter

Parametrised up/down modulo counter for the alarm-clock timekeeping chain (seconds, minutes, hours, day-of-month, alarm-set fields). It adds a non-zero lower bound, a runtime-adjustable upper bound, a synchronous preset load with range clamping, a wrap/saturate mode, and registered one-cycle carry/borrow pulses. Instances chain by wiring one stage's carry or borrow into the next stage's `en`. It replaces the fixed 0..n-1 wrap-only counter used in earlier time fields.

## Interface
- `W`, 6: counter width in bits.
- `MIN`, 0: lowest legal value, for example 1 for hours 1..12 or day 1..31.
- `MAX`, 59: static upper bound. Used when `DYN_LIM`=0, and as the ceiling on `lim` when `DYN_LIM`=1.
- `DYN_LIM`, 0: 1 selects the runtime `lim` port as the upper bound.
- Legal parameter set: 0 ≤ MIN ≤ MAX ≤ 2^W−1.

- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `en` in 1: count-step enable. Acts as the cascade input from the previous stage's `tc_up`/`tc_dn`.
- `up_down` in 1: 0 counts up, 1 counts down.
- `sat` in 1: 0 selects wrap mode, 1 selects saturate mode.
- `ld` in 1: synchronous preset load.
- `ld_val` in W: preset value.
- `lim` in W: runtime upper bound. Ignored when `DYN_LIM`=0.
- `count` out W: current value (registered).
- `tc_up` out 1: registered carry pulse, one cycle.
- `tc_dn` out 1: registered borrow pulse, one cycle.
- `at_max` out 1: combinational, `count` == effective upper bound.
- `at_min` out 1: combinational, `count` == MIN.

## Operation
- Effective upper bound `hi`:
  - `DYN_LIM`=0: `hi` = MAX.
  - `DYN_LIM`=1: `hi` = `lim`, clamped into [MIN, MAX].
- Priority per edge: reset > load > range clamp > count step > hold.
- Reset (`rst`=0):
  - `count` ← MIN.
  - `tc_up` ← 0, `tc_dn` ← 0.
- Load (`ld`=1):
  - `count` ← `ld_val` clamped into [MIN, `hi`].
  - No pulse is generated. `en` is ignored that cycle.
- Range clamp: if `count` > `hi` (for example `lim` was lowered) and `ld`=0, then `count` ← `hi`.
  - The clamp applies regardless of `en`.
  - No pulse is generated. The step is suppressed that cycle.
- Count step (`en`=1, in range, up direction):
  - `count` < `hi`: `count`+1.
  - `count` == `hi`, `sat`=0: `count` ← MIN and `tc_up` ← 1.
  - `count` == `hi`, `sat`=1: hold, no pulse.
- Count step (`en`=1, in range, down direction):
  - `count` > MIN: `count`−1.
  - `count` == MIN, `sat`=0: `count` ← `hi` and `tc_dn` ← 1.
  - `count` == MIN, `sat`=1: hold, no pulse.
- `en`=0: `count` holds.
- `tc_up`/`tc_dn` are 0 in every cycle that did not wrap. They are never both 1.
- Degenerate range `hi` == MIN: every enabled wrap-mode step leaves `count` at MIN and pulses `tc_up` or `tc_dn`.
- Arithmetic width: compare and increment at W+1 bits internally so that `hi` = 2^W−1 never overflows. `count` is always within [MIN, `hi`] one cycle after any `lim` change.

## Timing
- Latency: `count` updates on the edge where `en`/`ld` is sampled high and is visible in the following cycle.
- `tc_up`/`tc_dn` rise on the same edge as the wrap and stay high for exactly one cycle. Feeding one directly into the next stage's `en` advances that stage on the following edge, giving a one-cycle ripple per stage.
- `at_max`/`at_min` follow `count` and `lim` combinationally with no register delay.
- A change on `up_down` or `sat` takes effect at the next enabled edge. There is no settling cycle.
- Reset asserted mid-count overrides any `ld`/`en` on that edge. A pending pulse is cleared on the same edge.

## Test plan
- Wrap up, W=6, MIN=0, MAX=59, `sat`=0: load 58, then `en`=1 for 3 cycles → `count` goes 59, 0, 1. `tc_up`=1 only in the cycle `count` reads 0.
- Wrap down, MIN=1, MAX=12: reset, then `up_down`=1, `en`=1 for one cycle → `count` reads 1 after reset, then 12 with `tc_dn`=1 for one cycle.
- Saturate mode, MIN=0, MAX=59, `sat`=1: load 59, `en`=1 up for 4 cycles → `count` stays 59 and `tc_up` stays 0. Then switch to down at 0 → `count` holds 0 and `tc_dn` stays 0.
- Dynamic limit, `DYN_LIM`=1, MIN=1, MAX=31: `lim`=31, load 31, then set `lim`=28 → next edge `count`=28 with no pulse. `en` up once → `count`=1 with `tc_up`=1.
- Load clamp and priority, MIN=1, MAX=12: `ld_val`=0 gives `count`=1. `ld_val`=15 gives 12. `ld`=1 together with `en`=1 → the loaded value wins.
- Reset dominance: `rst`=0 together with `ld`=1 and `en`=1 at `count`=59 → `count`=MIN and both pulses are 0 the next cycle.
